// File: rtl/mod_updown_counter_pkg.sv
// Shared types for the up/down counter: count direction and boundary behaviour.
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  localparam int unsigned DEF_WIDTH = 4;

endpackage

// File: rtl/mod_updown_counter_if.sv
// Control/status bundle for the up/down counter; the master side drives it.
interface mod_updown_counter_if #(
  parameter int unsigned WIDTH = counter_pkg::DEF_WIDTH
);

  logic             en;
  logic             load;
  logic [WIDTH-1:0] data;
  logic             up_down;
  logic [WIDTH-1:0] limit;
  logic             sat_mode;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             sat;
  logic             at_max;
  logic             at_min;

  modport master (
    output en, load, data, up_down, limit, sat_mode,
    input  count, tc, sat, at_max, at_min
  );

  modport slave (
    input  en, load, data, up_down, limit, sat_mode,
    output count, tc, sat, at_max, at_min
  );

endinterface

// File: rtl/mod_updown_counter_updown_step.sv
// Combinational single-step rule: next count plus terminal-count/saturation flags.
module updown_step
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] i_count,
  input  logic [WIDTH-1:0] i_limit,
  input  dir_e             i_dir,
  input  mode_e            i_mode,
  output logic [WIDTH-1:0] o_next,
  output logic             o_tc,
  output logic             o_sat
);

  // Next-count decode; +1 only when count < limit, so it never overflows WIDTH bits
  always_comb begin
    o_next = i_count;
    o_tc   = 1'b0;
    o_sat  = 1'b0;
    if (i_dir == DIR_UP) begin
      if (i_count < i_limit) begin
        o_next = i_count + WIDTH'(1);
      end else if (i_mode == MODE_WRAP) begin
        o_next = '0;
        o_tc   = 1'b1;
      end else begin
        o_next = i_limit;
        o_sat  = 1'b1;
      end
    end else begin
      if (i_count > i_limit) begin
        // Limit was lowered under us: snap back into range silently
        o_next = i_limit;
      end else if (i_count != '0) begin
        o_next = i_count - WIDTH'(1);
      end else if (i_mode == MODE_WRAP) begin
        o_next = i_limit;
        o_tc   = 1'b1;
      end else begin
        o_sat  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Up/down modulo counter: registers plus the rst > load > en priority mux.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned    WIDTH   = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic                 clk,
  input logic                 rst,
  mod_updown_counter_if.slave bus
);

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_sat;

  logic [WIDTH-1:0] w_next;
  logic             w_tc;
  logic             w_sat;
  logic [WIDTH-1:0] w_load_val;

  updown_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_count (r_count),
    .i_limit (bus.limit),
    .i_dir   (dir_e'(bus.up_down)),
    .i_mode  (mode_e'(bus.sat_mode)),
    .o_next  (w_next),
    .o_tc    (w_tc),
    .o_sat   (w_sat)
  );

  assign w_load_val = (bus.data > bus.limit) ? bus.limit : bus.data;

  // State update; pulses default low so each lasts exactly one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= RST_VAL;
      r_tc    <= 1'b0;
      r_sat   <= 1'b0;
    end else if (bus.load) begin
      r_count <= w_load_val;
      r_tc    <= 1'b0;
      r_sat   <= 1'b0;
    end else if (bus.en) begin
      r_count <= w_next;
      r_tc    <= w_tc;
      r_sat   <= w_sat;
    end else begin
      r_tc    <= 1'b0;
      r_sat   <= 1'b0;
    end
  end

  assign bus.count  = r_count;
  assign bus.tc     = r_tc;
  assign bus.sat    = r_sat;
  assign bus.at_max = (r_count == bus.limit);
  assign bus.at_min = (r_count == '0);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: directed scenarios on 4- and 8-bit instances, then a
// randomized run of the 4-bit instance against an arithmetic reference model.
module tb_mod_updown_counter;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  // Reference model state for the 4-bit instance
  int m_count;
  bit m_tc;
  bit m_sat;

  always #5 clk = ~clk;

  mod_updown_counter_if #(.WIDTH(4)) u_bus4 ();
  mod_updown_counter_if #(.WIDTH(8)) u_bus8 ();

  mod_updown_counter #(.WIDTH(4), .RST_VAL(4'd0)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (u_bus4)
  );

  mod_updown_counter #(.WIDTH(8), .RST_VAL(8'd0)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (u_bus8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input int c, input bit t, input bit s);
    chk({tag, ".count"}, 32'(u_bus4.count), c);
    chk({tag, ".tc"}, 32'(u_bus4.tc), 32'(t));
    chk({tag, ".sat"}, 32'(u_bus4.sat), 32'(s));
  endtask

  task automatic load4(input int d);
    u_bus4.load = 1'b1;
    u_bus4.data = 4'(d);
    tick();
    u_bus4.load = 1'b0;
  endtask

  // Model: computed from the counting rules with plain integer arithmetic
  task automatic model_step(input bit r, input bit ld, input bit e, input bit up, input bit sm,
                            input int d, input int lim);
    m_tc  = 0;
    m_sat = 0;
    if (r) begin
      m_count = 0;
    end else if (ld) begin
      m_count = (d > lim) ? lim : d;
    end else if (e) begin
      if (up) begin
        if (m_count < lim) m_count = m_count + 1;
        else if (sm) begin m_count = lim; m_sat = 1; end
        else begin m_count = 0; m_tc = 1; end
      end else if (m_count > lim) begin
        m_count = lim;
      end else if (sm) begin
        if (m_count == 0) m_sat = 1;
        else m_count = m_count - 1;
      end else begin
        m_tc    = (m_count == 0);
        m_count = (m_count + lim) % (lim + 1);
      end
    end
  endtask

  initial begin
    int exp_c;
    rst = 1'b1;
    u_bus4.en = 1'b0; u_bus4.load = 1'b0; u_bus4.data = '0; u_bus4.up_down = 1'b1;
    u_bus4.limit = 4'd9; u_bus4.sat_mode = 1'b0;
    u_bus8.en = 1'b0; u_bus8.load = 1'b0; u_bus8.data = '0; u_bus8.up_down = 1'b1;
    u_bus8.limit = 8'd255; u_bus8.sat_mode = 1'b0;
    tick();
    tick();
    chk4("reset", 0, 0, 0);
    chk("reset.at_min", 32'(u_bus4.at_min), 1);
    chk("reset.at_max", 32'(u_bus4.at_max), 0);
    chk("reset8.count", 32'(u_bus8.count), 0);
    rst = 1'b0;

    // 1: wrap up through limit 9
    u_bus4.en = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      exp_c = (i <= 9) ? i : (i == 10) ? 0 : 1;
      chk4($sformatf("wrap_up[%0d]", i), exp_c, i == 10, 0);
    end

    // 2: wrap down from 0
    u_bus4.en = 1'b0;
    load4(0);
    chk4("load0", 0, 0, 0);
    chk("pre_down.at_min", 32'(u_bus4.at_min), 1);
    chk("pre_down.at_max", 32'(u_bus4.at_max), 0);
    u_bus4.en = 1'b1; u_bus4.up_down = 1'b0;
    tick();
    u_bus4.en = 1'b0;
    chk4("wrap_down", 9, 1, 0);
    chk("post_down.at_max", 32'(u_bus4.at_max), 1);
    tick();
    chk4("hold_no_pulse", 9, 0, 0);

    // 3: saturation at both ends
    u_bus4.sat_mode = 1'b1;
    u_bus4.en = 1'b1; u_bus4.up_down = 1'b1;
    tick();
    chk4("sat_up", 9, 0, 1);
    u_bus4.en = 1'b0;
    load4(0);
    u_bus4.en = 1'b1; u_bus4.up_down = 1'b0;
    tick();
    chk4("sat_down", 0, 0, 1);

    // 4: load wins over en and is clamped
    u_bus4.sat_mode = 1'b0; u_bus4.up_down = 1'b1;
    u_bus4.load = 1'b1; u_bus4.data = 4'd12;
    tick();
    u_bus4.load = 1'b0; u_bus4.en = 1'b0;
    chk4("load_clamp", 9, 0, 0);

    // 5: reset beats load and en; a reset glitch between edges is ignored
    load4(6);
    chk4("load6", 6, 0, 0);
    rst = 1'b1; u_bus4.en = 1'b1; u_bus4.load = 1'b1; u_bus4.data = 4'd3;
    tick();
    rst = 1'b0; u_bus4.load = 1'b0;
    chk4("rst_prio", 0, 0, 0);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    tick();
    chk4("rst_glitch", 1, 0, 0);
    u_bus4.en = 1'b0;

    // 6: limit lowered below count
    u_bus4.limit = 4'd15; load4(11); u_bus4.limit = 4'd5;
    u_bus4.en = 1'b1; u_bus4.up_down = 1'b1; u_bus4.sat_mode = 1'b0;
    tick();
    chk4("low_lim_wrap", 0, 1, 0);
    u_bus4.en = 1'b0;
    u_bus4.limit = 4'd15; load4(11); u_bus4.limit = 4'd5;
    u_bus4.en = 1'b1; u_bus4.sat_mode = 1'b1;
    tick();
    chk4("low_lim_sat", 5, 0, 1);
    u_bus4.en = 1'b0;
    u_bus4.limit = 4'd15; load4(11); u_bus4.limit = 4'd5;
    u_bus4.en = 1'b1; u_bus4.up_down = 1'b0;
    tick();
    chk4("low_lim_down", 5, 0, 0);

    // limit == 0 pins count and pulses every enabled cycle
    u_bus4.limit = 4'd0; u_bus4.sat_mode = 1'b0; u_bus4.up_down = 1'b1;
    tick();
    chk4("lim0_wrap_a", 0, 1, 0);
    tick();
    chk4("lim0_wrap_b", 0, 1, 0);
    u_bus4.sat_mode = 1'b1;
    tick();
    chk4("lim0_sat", 0, 0, 1);
    chk("lim0.at_max", 32'(u_bus4.at_max), 1);
    chk("lim0.at_min", 32'(u_bus4.at_min), 1);
    u_bus4.en = 1'b0;

    // 8-bit instance wraps at 255
    u_bus8.en = 1'b1;
    for (int i = 1; i <= 257; i++) begin
      tick();
      exp_c = (i <= 255) ? i : (i == 256) ? 0 : 1;
      if (i >= 254 || i <= 2) begin
        chk($sformatf("w8[%0d].count", i), 32'(u_bus8.count), exp_c);
        chk($sformatf("w8[%0d].tc", i), 32'(u_bus8.tc), 32'(i == 256));
      end
    end
    u_bus8.en = 1'b0;

    // Randomized run against the model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_count = 0; m_tc = 0; m_sat = 0;
    for (int i = 0; i < 400; i++) begin
      logic r_v, ld_v, en_v, up_v, sm_v;
      int   d_v, lim_v;
      r_v   = ($urandom_range(0, 39) == 0);
      ld_v  = ($urandom_range(0, 7) == 0);
      en_v  = ($urandom_range(0, 3) != 0);
      up_v  = 1'($urandom_range(0, 1));
      sm_v  = 1'($urandom_range(0, 1));
      d_v   = $urandom_range(0, 15);
      lim_v = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : int'(u_bus4.limit);
      if (i == 0) lim_v = 7;
      rst = r_v; u_bus4.load = ld_v; u_bus4.en = en_v; u_bus4.up_down = up_v;
      u_bus4.sat_mode = sm_v; u_bus4.data = 4'(d_v); u_bus4.limit = 4'(lim_v);
      model_step(r_v, ld_v, en_v, up_v, sm_v, d_v, lim_v);
      tick();
      chk4($sformatf("rand[%0d]", i), m_count, m_tc, m_sat);
      chk($sformatf("rand[%0d].at_max", i), 32'(u_bus4.at_max), 32'(m_count == lim_v));
      chk($sformatf("rand[%0d].at_min", i), 32'(u_bus4.at_min), 32'(m_count == 0));
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
